// File: rtl/clkgen_multi.sv
// clkgen_multi: multi-channel divided-clock generator running from one reference clock.
// Each channel has a programmable divide ratio and start phase, and a one-cycle enable
// strobe aligned to its rising edge. Every channel restarts together after a relock,
// so channels that share a ratio and phase stay edge-aligned.
module clkgen_multi #(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 5,
  parameter int LOCK_CYCLES = 16,
  localparam int CHW        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHW-1:0]        cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int SW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    LOCKING = 1'b0,
    RUN     = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     settle_q, settle_d;

  logic [DIV_W-1:0]  div_r   [NUM_CLOCKS];
  logic [DIV_W-1:0]  phase_r [NUM_CLOCKS];
  logic [DIV_W-1:0]  cnt_q   [NUM_CLOCKS];
  logic [DIV_W-1:0]  cnt_d   [NUM_CLOCKS];
  logic [DIV_W-1:0]  d_eff   [NUM_CLOCKS];
  logic [DIV_W-1:0]  p_eff   [NUM_CLOCKS];
  logic [DIV_W:0]    half    [NUM_CLOCKS];

  logic                  accept_any;
  logic                  accept_hit;
  logic                  run_d;
  logic [NUM_CLOCKS-1:0] outclk_d;
  logic [NUM_CLOCKS-1:0] outclk_en_d;

  // Requests are only taken in RUN; channels outside the array are accepted and dropped
  assign accept_any = cfg_valid && (state_q == RUN);
  assign accept_hit = accept_any && ({1'b0, cfg_chan} < (CHW + 1)'(NUM_CLOCKS));

  // Effective ratio (0 acts as 1), effective phase (out-of-range acts as 0) and high-time length
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      d_eff[i] = (div_r[i] == '0) ? DIV_W'(1) : div_r[i];
      p_eff[i] = (phase_r[i] < d_eff[i]) ? phase_r[i] : '0;
      half[i]  = ({1'b0, d_eff[i]} + (DIV_W + 1)'(1)) >> 1;
    end
  end

  // Next-state logic: settle for LOCK_CYCLES, then run until a valid channel is reprogrammed
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    case (state_q)
      LOCKING: begin
        settle_d = settle_q + SW'(1);
        if (settle_q == SW'(LOCK_CYCLES - 1)) begin
          state_d  = RUN;
          settle_d = '0;
        end
      end
      RUN: begin
        if (accept_hit) begin
          state_d  = LOCKING;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = LOCKING;
        settle_d = '0;
      end
    endcase
  end

  // Channel counters sit at their start phase while locking and wrap at d-1 while running
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((state_q == LOCKING) || accept_hit) begin
        cnt_d[i] = p_eff[i];
      end else if (cnt_q[i] == (d_eff[i] - DIV_W'(1))) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DIV_W'(1);
      end
    end
  end

  // Output values are derived from the next state so every output leaves a flop cleanly
  always_comb begin
    run_d       = (state_d == RUN);
    outclk_d    = '0;
    outclk_en_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      outclk_d[i]    = run_d && ({1'b0, cnt_d[i]} < half[i]);
      outclk_en_d[i] = run_d && (cnt_d[i] == '0);
    end
  end

  // FSM state and settle counter
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= LOCKING;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Per-channel configuration; reset restores the default ratio and zero phase
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_r[i]   <= DIV_W'(DEFAULT_DIV);
        phase_r[i] <= '0;
      end
    end else if (accept_hit) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        if (cfg_chan == CHW'(i)) begin
          div_r[i]   <= cfg_div;
          phase_r[i] <= cfg_phase;
        end
      end
    end
  end

  // Per-channel phase counters
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      outclk    <= '0;
      outclk_en <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      outclk    <= outclk_d;
      outclk_en <= outclk_en_d;
      locked    <= run_d;
      cfg_ready <= run_d;
    end
  end

endmodule

// File: tb/tb_clkgen_multi.sv
// tb_clkgen_multi: drives a 4-channel generator (16-cycle lock) and a 3-channel one
// (4-cycle lock, so channel 3 is an out-of-range request) and compares every output,
// every cycle, with a model that derives each channel's waveform from elapsed RUN time.
module tb_clkgen_multi;

  logic        refclk = 1'b0;
  logic        rst    = 1'b1;

  logic        a_valid, a_ready, a_locked;
  logic [1:0]  a_chan;
  logic [15:0] a_div, a_phase;
  logic [3:0]  a_clk, a_en;

  logic        b_valid, b_ready, b_locked;
  logic [1:0]  b_chan;
  logic [15:0] b_div, b_phase;
  logic [2:0]  b_clk, b_en;

  int tests    = 0;
  int failures = 0;
  int cycle    = 0;

  int numc  [2] = '{4, 3};
  int lockc [2] = '{16, 4};

  int   m_div     [2][4];
  int   m_ph      [2][4];
  bit   m_run     [2];
  int   m_elapsed [2];
  int   m_k       [2];

  logic cv  [2];
  int   cch [2];
  int   cdv [2];
  int   cph [2];

  bit clk_pat [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  bit en_pat  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  assign a_valid = cv[0];
  assign a_chan  = 2'(cch[0]);
  assign a_div   = 16'(cdv[0]);
  assign a_phase = 16'(cph[0]);
  assign b_valid = cv[1];
  assign b_chan  = 2'(cch[1]);
  assign b_div   = 16'(cdv[1]);
  assign b_phase = 16'(cph[1]);

  always #5 refclk = ~refclk;

  clkgen_multi #(.NUM_CLOCKS(4), .DIV_W(16), .DEFAULT_DIV(5), .LOCK_CYCLES(16)) dut_a (
    .refclk(refclk), .rst(rst), .cfg_valid(a_valid), .cfg_ready(a_ready),
    .cfg_chan(a_chan), .cfg_div(a_div), .cfg_phase(a_phase),
    .outclk(a_clk), .outclk_en(a_en), .locked(a_locked)
  );

  clkgen_multi #(.NUM_CLOCKS(3), .DIV_W(16), .DEFAULT_DIV(5), .LOCK_CYCLES(4)) dut_b (
    .refclk(refclk), .rst(rst), .cfg_valid(b_valid), .cfg_ready(b_ready),
    .cfg_chan(b_chan), .cfg_div(b_div), .cfg_phase(b_phase),
    .outclk(b_clk), .outclk_en(b_en), .locked(b_locked)
  );

  function automatic int effD(int div);
    return (div == 0) ? 1 : div;
  endfunction

  function automatic int effP(int div, int ph);
    return (ph < effD(div)) ? ph : 0;
  endfunction

  task automatic modelReset();
    for (int n = 0; n < 2; n++) begin
      m_run[n]     = 1'b0;
      m_elapsed[n] = 0;
      m_k[n]       = 0;
      for (int c = 0; c < 4; c++) begin
        m_div[n][c] = 5;
        m_ph[n][c]  = 0;
      end
    end
  endtask

  task automatic modelEdge();
    for (int n = 0; n < 2; n++) begin
      if (m_run[n]) begin
        if (cv[n] && (cch[n] < numc[n])) begin
          m_div[n][cch[n]] = cdv[n];
          m_ph[n][cch[n]]  = cph[n];
          m_run[n]         = 1'b0;
          m_elapsed[n]     = 0;
        end else begin
          m_k[n]++;
        end
      end else begin
        m_elapsed[n]++;
        if (m_elapsed[n] == lockc[n]) begin
          m_run[n] = 1'b1;
          m_k[n]   = 0;
        end
      end
    end
  endtask

  task automatic cmp(string tag, int n, logic [3:0] obs, logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s inst%0d cycle%0d: observed %b expected %b", tag, n, cycle, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [3:0] ec, ee, oc, oe;
    int d, p, cnt;
    for (int n = 0; n < 2; n++) begin
      ec = '0;
      ee = '0;
      if (m_run[n]) begin
        for (int c = 0; c < numc[n]; c++) begin
          d     = effD(m_div[n][c]);
          p     = effP(m_div[n][c], m_ph[n][c]);
          cnt   = (p + m_k[n]) % d;
          ec[c] = (cnt < (d + 1) / 2);
          ee[c] = (cnt == 0);
        end
      end
      oc = (n == 0) ? a_clk : {1'b0, b_clk};
      oe = (n == 0) ? a_en  : {1'b0, b_en};
      cmp("outclk", n, oc, ec);
      cmp("outclk_en", n, oe, ee);
      cmp("locked", n, {3'b0, (n == 0) ? a_locked : b_locked}, {3'b0, m_run[n]});
      cmp("cfg_ready", n, {3'b0, (n == 0) ? a_ready : b_ready}, {3'b0, m_run[n]});
    end
  endtask

  task automatic stepCycle(int count);
    repeat (count) begin
      @(posedge refclk);
      if (!rst) modelEdge();
      cycle++;
      #1;
      checkOutput();
    end
  endtask

  task automatic applyStimulus(int n, logic v, int ch, int dv, int ph);
    cv[n]  = v;
    cch[n] = ch;
    cdv[n] = dv;
    cph[n] = ph;
  endtask

  task automatic waitBothRunning();
    for (int w = 0; w < 40 && !(m_run[0] && m_run[1]); w++) stepCycle(1);
  endtask

  initial begin
    applyStimulus(0, 1'b0, 0, 0, 0);
    applyStimulus(1, 1'b0, 0, 0, 0);
    modelReset();

    // reset state, then release between edges and watch the lock
    #7;
    checkOutput();
    stepCycle(2);
    @(negedge refclk);
    rst = 1'b0;
    stepCycle(16);

    // default 5-cycle pattern on all channels, edge-aligned
    for (int i = 0; i < 10; i++) begin
      cmp("default_clk", 0, a_clk, {4{clk_pat[i % 5]}});
      cmp("default_en", 0, a_en, {4{en_pat[i % 5]}});
      stepCycle(1);
    end

    // channel 2 -> ratio 4, phase 1
    applyStimulus(0, 1'b1, 2, 4, 1);
    stepCycle(1);
    applyStimulus(0, 1'b0, 0, 0, 0);
    stepCycle(24);

    // ratio 0 then ratio 1 on channel 0
    applyStimulus(0, 1'b1, 0, 0, 0);
    stepCycle(1);
    applyStimulus(0, 1'b0, 0, 0, 0);
    stepCycle(20);
    applyStimulus(0, 1'b1, 0, 1, 0);
    stepCycle(1);
    applyStimulus(0, 1'b0, 0, 0, 0);
    stepCycle(20);

    // phase beyond the ratio falls back to 0
    applyStimulus(0, 1'b1, 1, 6, 9);
    stepCycle(1);
    applyStimulus(0, 1'b0, 0, 0, 0);
    stepCycle(20);

    // request held through LOCKING is only taken once RUN resumes
    applyStimulus(0, 1'b1, 3, 3, 2);
    stepCycle(1);
    applyStimulus(0, 1'b1, 0, 7, 3);
    stepCycle(17);
    applyStimulus(0, 1'b0, 0, 0, 0);
    stepCycle(24);

    // out-of-range channel on the 3-channel instance is dropped without relock
    waitBothRunning();
    applyStimulus(1, 1'b1, 3, 2, 0);
    stepCycle(1);
    applyStimulus(1, 1'b0, 0, 0, 0);
    stepCycle(6);

    // randomized reprogramming of both instances
    for (int it = 0; it < 8; it++) begin
      waitBothRunning();
      applyStimulus(0, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 9)));
      applyStimulus(1, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                    int'($urandom_range(0, 9)));
      stepCycle(1);
      applyStimulus(0, 1'b0, 0, 0, 0);
      applyStimulus(1, 1'b0, 0, 0, 0);
      stepCycle(int'($urandom_range(18, 30)));
    end

    // asynchronous reset mid-RUN, then recovery to the default ratio
    waitBothRunning();
    @(negedge refclk);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    stepCycle(2);
    @(negedge refclk);
    #1;
    rst = 1'b0;
    stepCycle(28);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
